uart_tx_fifo: RTL
=================

# uart_tx_fifo

UART transmitter for the FPGA link: accepts bytes from the on-chip result path, buffers them in a small FIFO, and serializes them as 8N1 frames on the FTDI serial output (FTDI_BDBUS_1) back to the host. It is the host-bound counterpart of the host-to-FPGA receive path, at the same bit rate: 57600 baud from the 48 MHz PLL clock, 17361.1 ns per symbol.

## Interface
- CLKS_PER_BIT, 833 — clock cycles per UART symbol (48 MHz / 57600); legal range ≥ 2.
- FIFO_DEPTH, 16 — byte FIFO depth; power of two, ≥ 2.
- CW, $clog2(FIFO_DEPTH)+1 — width of fifo_count (derived, not overridden).

- clk  in  1  system clock, 48 MHz; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte this cycle.
- tx  out  1  serial line, idle high; drives FTDI_BDBUS_1.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  CW  bytes currently buffered (0..FIFO_DEPTH).

## Operation
- Handshake:
  - A byte is pushed on a rising edge when tx_valid && tx_ready.
  - tx_ready = !full && !rst.
  - tx_data is ignored when tx_valid is low or when full.
- FIFO:
  - Circular buffer with read/write pointers that wrap at FIFO_DEPTH.
  - Push and pop on the same edge leave fifo_count unchanged and both pointers advance.
  - Pop from empty never occurs.
  - Write when full is blocked by tx_ready = 0.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx = 1. If FIFO non-empty, pop the head into the shift register, clear baud_cnt and bit_idx, go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0], LSB first. Every CLKS_PER_BIT cycles shift right and increment bit_idx. After bit_idx 7 completes, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps. A symbol ends on the cycle where baud_cnt == CLKS_PER_BIT-1.
- tx is a registered output with no combinational path from state to pin.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset (including mid-frame):
  - On the edge where rst is sampled high: state ← IDLE, tx ← 1, FIFO flushed (pointers and count ← 0), shift register, baud_cnt and bit_idx ← 0.
  - Any partial frame is abandoned.
  - A push presented during rst is dropped.

## Timing
- Reset values: tx = 1, tx_ready = 0 while rst is high and 1 on the first cycle after, busy = 0, fifo_count = 0.
- Latency: a byte pushed into an empty FIFO with the FSM in IDLE at edge N gives tx falling at edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles: start, D0..D7, stop.
- Each symbol is held exactly CLKS_PER_BIT cycles, with no jitter and no cumulative drift.
- fifo_count updates on the edge after the push or pop.
- fifo_count increments on a push and decrements when IDLE or STOP pops.
- Pop at the STOP→START transition is the same edge on which tx goes low.
- Streaming: K bytes pushed faster than the line rate produce K contiguous frames spanning 10·K·CLKS_PER_BIT cycles, with tx low immediately after each stop bit.
- Full: after FIFO_DEPTH pushes with no pop, tx_ready drops on the following cycle. It returns to 1 on the cycle after the next pop.

## Test plan
- Reset then idle (CLKS_PER_BIT = 8): hold rst 5 cycles, release → tx = 1, tx_ready = 1, busy = 0, fifo_count = 0 for 100 cycles.
- Single byte 8'hA5 (CLKS_PER_BIT = 8):
  - tx falls 1 cycle after the push edge.
  - Sampling the line mid-symbol gives 0,1,0,1,0,0,1,0,1,1.
  - Each symbol is 8 cycles and the frame is 80 cycles.
  - busy falls after the stop bit.
- Back-to-back 8'h00 then 8'hFF: frame 2's start bit begins on the cycle right after frame 1's stop bit, total 160 cycles, no idle gap.
- Fill FIFO_DEPTH = 16 (CLKS_PER_BIT = 833):
  - The first byte is popped at once, then tx_valid is held with 16 more bytes.
  - tx_ready = 0 with fifo_count = 16.
  - A 17th byte held on tx_valid is not accepted until the next pop.
  - A 0x00..0x10 sequence arrives intact and in order.
- Pointer wrap: stream 40 bytes 0x00..0x27 through FIFO_DEPTH = 4 → host-side decoder reconstructs all 40 in order.
- Reset mid-frame: assert rst during D3 of 8'h3C with 3 bytes queued → next edge tx = 1, fifo_count = 0, busy = 0; a new byte 8'h81 afterwards transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the on-chip result path and the UART transmit FIFO.
// The master drives the byte and its valid flag, and the slave returns ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a circular byte FIFO.
// When the FIFO still holds data, frames are sent back to back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 833,
  parameter int FIFO_DEPTH   = 16,
  parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shift, shift_nxt;
  logic [BW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          tx_nxt;
  logic          full, empty, push, pop, sym_end;

  assign full         = (fifo_count == DEPTH_CNT);
  assign empty        = (fifo_count == '0);
  assign bus.tx_ready = !full && !rst;
  assign push         = bus.tx_valid && bus.tx_ready;
  assign sym_end      = (baud_cnt == LAST_TICK);
  assign busy         = (state != IDLE) || !empty;

  // Reset flushes the FIFO through its pointers. Stale storage contents are never read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      tx       <= tx_nxt;
    end
  end

  // The line level is derived from the next state, so tx changes on the same edge as the state.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    baud_cnt_nxt = sym_end ? '0 : baud_cnt + BW'(1);
    bit_idx_nxt  = bit_idx;
    pop          = 1'b0;
    tx_nxt       = 1'b1;

    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
        end
      end
      START: begin
        if (sym_end) state_nxt = DATA;
      end
      DATA: begin
        if (sym_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (sym_end) begin
          bit_idx_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule
